// File: rtl/mp2_synth_window_mac_if.sv
// Bus bundle for the MP2 synthesis windowing/MAC stage.
//   start/v_offset         : block trigger and V-block base address
//   busy/done              : block status
//   win_address/win_data   : window buffer RAM read port (1-cycle latency)
//   coef_address/coef_data : coefficient ROM read port (1-cycle latency)
//   pcm_data/valid/ready   : PCM sample output handshake
// master = the MAC stage, slave = its surroundings.
interface mp2_synth_window_mac_if;
    logic        start;
    logic [9:0]  v_offset;
    logic        busy;
    logic        done;
    logic [9:0]  win_address;
    logic [15:0] win_data;
    logic [8:0]  coef_address;
    logic [15:0] coef_data;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;

    modport master (
        input  start, v_offset, win_data, coef_data, pcm_ready,
        output busy, done, win_address, coef_address, pcm_data, pcm_valid
    );

    modport slave (
        output start, v_offset, win_data, coef_data, pcm_ready,
        input  busy, done, win_address, coef_address, pcm_data, pcm_valid
    );
endinterface

// File: rtl/mp2_synth_window_mac.sv
// Windowing/MAC stage of the MP2 polyphase synthesis filter.
// For each start it walks the circular V vector in the window buffer RAM,
// multiplies 16 taps per sample by Q2.14 coefficients D[0..511] and emits
// 32 rounded, saturated signed 16-bit PCM samples over valid/ready.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mp2_synth_window_mac_if.master (start/status, RAM/ROM read
//           ports, PCM output handshake)
module mp2_synth_window_mac #(
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 36
) (
    input  logic                          clock,
    input  logic                          reset,
    mp2_synth_window_mac_if.master        bus
);
    localparam int STAGES = 2;  // address -> data -> product -> accumulate

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] PCM_MAX = 32767;
    localparam logic signed [ACC_W-1:0] PCM_MIN = -32768;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    state_t state, state_nxt;

    logic [9:0]              voff;
    logic [4:0]              j;
    logic [3:0]              tap;       // tap index in ISSUE, drain count in DRAIN
    logic                    issue;
    logic [STAGES:1]         vld_pipe;
    logic [9:0]              vidx;
    logic [9:0]              win_calc;
    logic [8:0]              coef_calc;
    logic [9:0]              win_hold;
    logic [8:0]              coef_hold;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shr;
    logic [15:0]             sat;

    assign issue = (state == ISSUE);

    // Even taps read 128k+j, odd taps 128k+96+j; 10-bit add wraps the circular buffer.
    assign vidx      = {tap[3:1], 7'd0} + (tap[0] ? 10'd96 : 10'd0) + {5'd0, j};
    assign win_calc  = voff + vidx;
    assign coef_calc = {tap, j};  // 32*tap + j

    // Addresses track the current tap while issuing and hold their last value otherwise.
    assign bus.win_address  = issue ? win_calc  : win_hold;
    assign bus.coef_address = issue ? coef_calc : coef_hold;

    always_comb begin
        rnd = acc + RND;
        shr = rnd >>> COEF_FRAC;
        if (shr > PCM_MAX)
            sat = 16'h7FFF;
        else if (shr < PCM_MIN)
            sat = 16'h8000;
        else
            sat = shr[15:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ISSUE;
            ISSUE:   if (tap == 4'd15) state_nxt = DRAIN;
            DRAIN:   if (tap == 4'd2) state_nxt = OUTPUT;
            OUTPUT:  if (bus.pcm_ready) state_nxt = (j == 5'd31) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            voff          <= '0;
            j             <= '0;
            tap           <= '0;
            vld_pipe      <= '0;
            win_hold      <= '0;
            coef_hold     <= '0;
            prod          <= '0;
            acc           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pcm_valid <= 1'b0;
            bus.pcm_data  <= '0;
        end else begin
            bus.done <= 1'b0;
            vld_pipe <= {vld_pipe[1], issue};

            // RAM/ROM data arrives the cycle after its address.
            if (vld_pipe[1])
                prod <= $signed(bus.win_data) * $signed(bus.coef_data);

            // Clearing at tap 0 is safe: the previous sample's last add finished in DRAIN.
            if (issue && tap == 4'd0)
                acc <= '0;
            else if (vld_pipe[2])
                acc <= acc + $signed({{(ACC_W-32){prod[31]}}, prod});

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        voff     <= bus.v_offset;
                        j        <= '0;
                        tap      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    win_hold  <= win_calc;
                    coef_hold <= coef_calc;
                    tap       <= tap + 4'd1;  // wraps 15 -> 0 for DRAIN
                end
                DRAIN: begin
                    if (tap == 4'd2) begin
                        tap           <= '0;
                        bus.pcm_data  <= sat;
                        bus.pcm_valid <= 1'b1;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                OUTPUT: begin
                    if (bus.pcm_ready) begin
                        bus.pcm_valid <= 1'b0;
                        if (j == 5'd31) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            j <= j + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mp2_synth_window_mac.sv
module tb_mp2_synth_window_mac;
    logic clock = 1'b0;
    logic reset = 1'b1;

    mp2_synth_window_mac_if bus();

    mp2_synth_window_mac #(.COEF_FRAC(14), .ACC_W(36)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] win_mem  [1024];
    logic [15:0] coef_mem [512];

    always @(posedge clock) begin
        bus.win_data  <= win_mem[bus.win_address];
        bus.coef_data <= coef_mem[bus.coef_address];
    end

    int          vec = 0;
    int          err = 0;
    logic [15:0] samples [$];
    int          lats [$];
    int          done_cnt;
    int          stall_bad;
    logic        busy_after;
    logic [9:0]  wa [16];
    logic [8:0]  ca [16];

    localparam logic [9:0] WRAP_EXP [16] = '{
        10'h3C0, 10'h020, 10'h040, 10'h0A0, 10'h0C0, 10'h120, 10'h140, 10'h1A0,
        10'h1C0, 10'h220, 10'h240, 10'h2A0, 10'h2C0, 10'h320, 10'h340, 10'h3A0
    };

    task automatic fill(input logic [15:0] v, input logic [15:0] d);
        for (int a = 0; a < 1024; a++) win_mem[a] = v;
        for (int a = 0; a < 512; a++) coef_mem[a] = d;
    endtask

    // V[a] = 16*(a mod 32), D = 1.0: sample j (offset 0) sums 16 taps of 16*j -> 256*j.
    task automatic fill_ramp();
        for (int a = 0; a < 1024; a++) win_mem[a] = 16'(16 * (a % 32));
        for (int a = 0; a < 512; a++) coef_mem[a] = 16'h4000;
    endtask

    // Runs one block and records observations; the test tasks compare them.
    task automatic run_block(input logic [9:0] off, input int stall_at, input int stall_len,
                             output bit to);
        int cyc, t0, stalled;
        logic pv_q;
        logic [15:0] d0;
        logic [9:0] a0;
        samples.delete(); lats.delete();
        done_cnt = 0; stall_bad = 0; to = 1;
        cyc = 0; t0 = 0; stalled = 0; pv_q = 0; d0 = '0; a0 = '0;
        @(negedge clock);
        bus.v_offset = off; bus.start = 1; bus.pcm_ready = 1;
        @(posedge clock); #1 bus.start = 0;
        while (cyc < 4000) begin
            @(negedge clock); cyc++;
            bus.start = 0;
            if (cyc <= 16) begin
                wa[cyc-1] = bus.win_address;
                ca[cyc-1] = bus.coef_address;
            end
            if (bus.busy && bus.coef_address < 9'd32) t0 = cyc;
            if (bus.pcm_valid && !pv_q) lats.push_back(cyc - t0);
            pv_q = bus.pcm_valid;
            if (bus.done) begin done_cnt++; to = 0; break; end
            bus.pcm_ready = 1;
            if (stall_len > 0 && samples.size() == stall_at && stalled < stall_len) begin
                bus.pcm_ready = 0;
                if (bus.pcm_valid) begin
                    if (stalled == 0) begin
                        d0 = bus.pcm_data; a0 = bus.win_address;
                    end else if (bus.pcm_data !== d0 || bus.win_address !== a0) begin
                        stall_bad++;
                    end
                    if (stalled == 3) begin bus.start = 1; bus.v_offset = 10'h155; end
                    stalled++;
                end
            end
            if (bus.pcm_valid && bus.pcm_ready) samples.push_back(bus.pcm_data);
        end
        @(negedge clock);
        bus.start = 0;
        busy_after = bus.busy;
        for (int n = 0; n < 3; n++) begin
            if (bus.done) done_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.v_offset = '0; bus.pcm_ready = 0;
        reset = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL reset_done got %0b want 0", bus.done); end
        vec++; if (bus.pcm_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %0b want 0", bus.pcm_valid); end
        vec++; if (bus.pcm_data !== 16'h0000) begin err++; $display("FAIL reset_pcm got %h want 0000", bus.pcm_data); end
        vec++; if (bus.win_address !== 10'h000) begin err++; $display("FAIL reset_win got %h want 000", bus.win_address); end
        vec++; if (bus.coef_address !== 9'h000) begin err++; $display("FAIL reset_coef got %h want 000", bus.coef_address); end
        reset = 0;
    endtask

    task automatic test_zero();
        bit to;
        fill(16'h0000, 16'h1234);
        run_block(10'h000, 0, 0, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL zero_timeout got %0b want 0", to); end
        vec++; if (samples.size() !== 32) begin err++; $display("FAIL zero_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            vec++; if (samples[n] !== 16'h0000) begin err++; $display("FAIL zero_sample[%0d] got %h want 0000", n, samples[n]); end
        end
        vec++; if (done_cnt !== 1) begin err++; $display("FAIL zero_done got %0d want 1", done_cnt); end
        vec++; if (busy_after !== 1'b0) begin err++; $display("FAIL zero_busy_after got %0b want 0", busy_after); end
    endtask

    task automatic test_unity();
        bit to;
        fill(16'h0100, 16'h4000);
        run_block(10'h000, 0, 0, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL unity_timeout got %0b want 0", to); end
        vec++; if (samples.size() !== 32) begin err++; $display("FAIL unity_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            vec++; if (samples[n] !== 16'h1000) begin err++; $display("FAIL unity_sample[%0d] got %h want 1000", n, samples[n]); end
        end
        vec++; if (lats.size() !== 32) begin err++; $display("FAIL unity_lat_count got %0d want 32", lats.size()); end
        foreach (lats[n]) begin
            vec++; if (lats[n] !== 19) begin err++; $display("FAIL unity_latency[%0d] got %0d want 19", n, lats[n]); end
        end
    endtask

    task automatic test_saturate();
        bit to;
        fill(16'h7FFF, 16'h4000);
        run_block(10'h000, 0, 0, to);
        vec++; if (samples.size() !== 32 || to) begin err++; $display("FAIL sat_pos_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            vec++; if (samples[n] !== 16'h7FFF) begin err++; $display("FAIL sat_pos[%0d] got %h want 7fff", n, samples[n]); end
        end
        fill(16'h7FFF, 16'hC000);
        run_block(10'h000, 0, 0, to);
        vec++; if (samples.size() !== 32 || to) begin err++; $display("FAIL sat_neg_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            vec++; if (samples[n] !== 16'h8000) begin err++; $display("FAIL sat_neg[%0d] got %h want 8000", n, samples[n]); end
        end
    endtask

    task automatic test_wrap();
        bit to;
        logic [8:0] ce;
        fill(16'h0000, 16'h4000);
        run_block(10'h3C0, 0, 0, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL wrap_timeout got %0b want 0", to); end
        for (int i = 0; i < 16; i++) begin
            ce = 9'(32 * i);
            vec++; if (wa[i] !== WRAP_EXP[i]) begin err++; $display("FAIL wrap_win[%0d] got %h want %h", i, wa[i], WRAP_EXP[i]); end
            vec++; if (ca[i] !== ce) begin err++; $display("FAIL wrap_coef[%0d] got %0d want %0d", i, ca[i], ce); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [15:0] e;
        fill_ramp();
        run_block(10'h000, 5, 10, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL bp_timeout got %0b want 0", to); end
        vec++; if (stall_bad !== 0) begin err++; $display("FAIL bp_stall_changes got %0d want 0", stall_bad); end
        vec++; if (samples.size() !== 32) begin err++; $display("FAIL bp_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            e = 16'(256 * n);
            vec++; if (samples[n] !== e) begin err++; $display("FAIL bp_sample[%0d] got %h want %h", n, samples[n], e); end
        end
        vec++; if (done_cnt !== 1) begin err++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        int nhs;
        logic [15:0] e;
        fill_ramp();
        nhs = 0; hit = 0;
        @(negedge clock);
        bus.v_offset = 10'h000; bus.start = 1; bus.pcm_ready = 1;
        @(posedge clock); #1 bus.start = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (nhs == 3 && bus.busy && bus.coef_address == 9'd227) begin hit = 1; break; end
            if (bus.pcm_valid && bus.pcm_ready) nhs++;
        end
        vec++; if (hit !== 1'b1) begin err++; $display("FAIL rst_mid_reach got %0b want 1", hit); end
        reset = 1;
        @(negedge clock);
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL rst_mid_busy got %0b want 0", bus.busy); end
        vec++; if (bus.pcm_valid !== 1'b0) begin err++; $display("FAIL rst_mid_valid got %0b want 0", bus.pcm_valid); end
        vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL rst_mid_done got %0b want 0", bus.done); end
        reset = 0;
        run_block(10'h000, 0, 0, to);
        vec++; if (samples.size() !== 32 || to) begin err++; $display("FAIL rst_mid_count got %0d want 32", samples.size()); end
        foreach (samples[n]) begin
            e = 16'(256 * n);
            vec++; if (samples[n] !== e) begin err++; $display("FAIL rst_mid_sample[%0d] got %h want %h", n, samples[n], e); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_unity();
        test_saturate();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
